// File: rtl/mdio_responder.sv
// mdio_responder: Clause-22 MDIO PHY-side responder bridging MDC/MDIO frames to a register port.
// Build option: define MDIO_PREAMBLE_SUPPRESS_EN to accept ST after a single preamble 1.
module mdio_responder #(
    parameter logic [4:0] PHY_ADDR    = 5'd1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        nRST,
    input  logic        mdc,
    input  logic        mdio_i,
    output logic        mdio_o,
    output logic        mdio_t,
    output logic [4:0]  reg_addr,
    output logic [15:0] reg_wdata,
    output logic        reg_we,
    output logic        reg_re,
    input  logic [15:0] reg_rdata,
    output logic        frame_err,
    output logic        busy
);

`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam logic [5:0] PRE_MIN = 6'd1;
`else
    localparam logic [5:0] PRE_MIN = 6'd32;
`endif

    typedef enum logic [2:0] {
        S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA
    } state_t;

    logic [SYNC_STAGES-1:0] mdc_sync_q;
    logic [SYNC_STAGES-1:0] mdio_sync_q;
    logic                   mdc_prev_q;
    logic                   mdc_s, mdio_s, rise, fall;

    state_t      state_q, state_d;
    logic [5:0]  bit_q, bit_d;
    logic [5:0]  pre_q, pre_d;
    logic [15:0] sh_q, sh_d;
    logic [15:0] rd_q, rd_d;
    logic        rd_op_q, rd_op_d;
    logic        cap_q, cap_d;
    logic        mdio_o_q, mdio_o_d;
    logic        mdio_t_q, mdio_t_d;
    logic [4:0]  addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic        we_q, we_d;
    logic        re_q, re_d;
    logic        err_q, err_d;
    logic [5:0]  nbit;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            mdc_sync_q  <= '0;
            mdio_sync_q <= '1;
            mdc_prev_q  <= 1'b0;
        end else begin
            mdc_sync_q  <= {mdc_sync_q[SYNC_STAGES-2:0], mdc};
            mdio_sync_q <= {mdio_sync_q[SYNC_STAGES-2:0], mdio_i};
            mdc_prev_q  <= mdc_sync_q[SYNC_STAGES-1];
        end
    end

    assign mdc_s  = mdc_sync_q[SYNC_STAGES-1];
    assign mdio_s = mdio_sync_q[SYNC_STAGES-1];
    assign rise   = mdc_s & ~mdc_prev_q;
    assign fall   = ~mdc_s & mdc_prev_q;

    always_ff @(posedge clk or negedge nRST) begin
        if (!nRST) begin
            state_q  <= S_IDLE;
            bit_q    <= '0;
            pre_q    <= '0;
            sh_q     <= '0;
            rd_q     <= '0;
            rd_op_q  <= 1'b0;
            cap_q    <= 1'b0;
            mdio_o_q <= 1'b1;
            mdio_t_q <= 1'b1;
            addr_q   <= '0;
            wdata_q  <= '0;
            we_q     <= 1'b0;
            re_q     <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            bit_q    <= bit_d;
            pre_q    <= pre_d;
            sh_q     <= sh_d;
            rd_q     <= rd_d;
            rd_op_q  <= rd_op_d;
            cap_q    <= cap_d;
            mdio_o_q <= mdio_o_d;
            mdio_t_q <= mdio_t_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            we_q     <= we_d;
            re_q     <= re_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        bit_d    = bit_q;
        pre_d    = pre_q;
        sh_d     = sh_q;
        rd_d     = rd_q;
        rd_op_d  = rd_op_q;
        cap_d    = re_q;
        mdio_o_d = mdio_o_q;
        mdio_t_d = mdio_t_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        we_d     = 1'b0;
        re_d     = 1'b0;
        err_d    = 1'b0;
        nbit     = bit_q + 6'd1;

        // Register bank answers one cycle after the read strobe.
        if (cap_q) rd_d = reg_rdata;

        if (rise) begin
            if (state_q == S_IDLE) begin
                if (mdio_s) begin
                    pre_d = (pre_q == 6'd32) ? pre_q : pre_q + 6'd1;
                end else if (pre_q >= PRE_MIN) begin
                    state_d = S_ST;
                    bit_d   = 6'd1;
                    pre_d   = '0;
                end else begin
                    pre_d = '0;
                end
            end else begin
                sh_d  = {sh_q[14:0], mdio_s};
                bit_d = nbit;
                case (state_q)
                    S_ST: begin
                        if (mdio_s) begin
                            state_d = S_OP;
                        end else begin
                            err_d   = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    S_OP: begin
                        if (nbit == 6'd4) begin
                            if (sh_d[1:0] == 2'b10 || sh_d[1:0] == 2'b01) begin
                                rd_op_d = sh_d[1];
                                state_d = S_PHYAD;
                            end else begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end
                        end
                    end
                    S_PHYAD: begin
                        if (nbit == 6'd9) begin
                            state_d = (sh_d[4:0] == PHY_ADDR) ? S_REGAD : S_IDLE;
                        end
                    end
                    S_REGAD: begin
                        if (nbit == 6'd14) begin
                            addr_d  = sh_d[4:0];
                            re_d    = rd_op_q;
                            state_d = S_TA;
                        end
                    end
                    S_TA: begin
                        if (nbit == 6'd16) begin
                            if (!rd_op_q && sh_d[1:0] != 2'b10) begin
                                err_d   = 1'b1;
                                state_d = S_IDLE;
                            end else begin
                                state_d = S_DATA;
                            end
                        end
                    end
                    S_DATA: begin
                        if (nbit == 6'd32 && !rd_op_q) begin
                            wdata_d = sh_d;
                            we_d    = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                    default: state_d = S_IDLE;
                endcase
            end
        end

        // Read turnaround and data are launched on MDC falls.
        if (fall && rd_op_q && (state_q == S_TA || state_q == S_DATA)) begin
            if (bit_q == 6'd15) begin
                mdio_t_d = 1'b0;
                mdio_o_d = 1'b0;
            end else if (bit_q >= 6'd16 && bit_q <= 6'd31) begin
                mdio_o_d = rd_q[15];
                rd_d     = {rd_q[14:0], 1'b0};
            end else if (bit_q == 6'd32) begin
                state_d = S_IDLE;
            end
        end

        if (state_d == S_IDLE) begin
            mdio_t_d = 1'b1;
            mdio_o_d = 1'b1;
            bit_d    = '0;
        end
    end

    assign mdio_o    = mdio_o_q;
    assign mdio_t    = mdio_t_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_we    = we_q;
    assign reg_re    = re_q;
    assign frame_err = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mdio_responder.sv
// tb_mdio_responder: MDIO master model plus register bank driving mdio_responder.
// Expected frame outcomes come from a frame-level model of the protocol rules.
module tb_mdio_responder;

    localparam logic [4:0] PHY  = 5'd1;
    localparam int         HALF = 8;
    localparam int         TRAIL = 2;
`ifdef MDIO_PREAMBLE_SUPPRESS_EN
    localparam int PRE_MIN = 1;
`else
    localparam int PRE_MIN = 32;
`endif

    typedef struct {
        int          we;
        int          re;
        int          err;
        logic        drive;
        logic [4:0]  addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    logic        clk = 1'b0;
    logic        nRST = 1'b0;
    logic        mdc = 1'b0;
    logic        m_en = 1'b0;
    logic        m_val = 1'b1;
    logic        line;
    logic        mdio_o, mdio_t, reg_we, reg_re, frame_err, busy;
    logic [4:0]  reg_addr;
    logic [15:0] reg_wdata;
    logic [15:0] reg_rdata = '0;
    logic [15:0] mem [32];

    int checks = 0;
    int errors = 0;
    int n_we = 0, n_re = 0, n_err = 0, n_tlow = 0;
    int d_we, d_re, d_err, d_tlow;
    logic [4:0]  we_addr, re_addr;
    logic [15:0] we_data;
    logic [1:32] rx;

    // Open-drain bus with pull-up: responder wins when it drives.
    assign line = !mdio_t ? mdio_o : (m_en ? m_val : 1'b1);

    mdio_responder #(.PHY_ADDR(PHY), .SYNC_STAGES(2)) dut (
        .clk(clk), .nRST(nRST), .mdc(mdc), .mdio_i(line),
        .mdio_o(mdio_o), .mdio_t(mdio_t),
        .reg_addr(reg_addr), .reg_wdata(reg_wdata),
        .reg_we(reg_we), .reg_re(reg_re), .reg_rdata(reg_rdata),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (reg_re) reg_rdata <= mem[reg_addr];

    always @(negedge clk) begin
        if (reg_we) begin
            n_we++;
            we_addr = reg_addr;
            we_data = reg_wdata;
        end
        if (reg_re) begin
            n_re++;
            re_addr = reg_addr;
        end
        if (frame_err) n_err++;
        if (!mdio_t) n_tlow++;
    end

    function automatic exp_t model(input int ones, input logic [1:0] op,
                                   input logic [4:0] pa, input logic [4:0] ra,
                                   input logic [1:0] ta, input logic [15:0] d);
        exp_t e;
        e.we = 0; e.re = 0; e.err = 0; e.drive = 1'b0;
        e.addr = ra; e.wdata = d; e.rdata = mem[ra];
        if (ones < PRE_MIN) return e;
        if (op == 2'b00 || op == 2'b11) begin
            e.err = 1;
        end else if (pa == PHY) begin
            if (op == 2'b10) begin
                e.re = 1;
                e.drive = 1'b1;
            end else if (ta == 2'b10) begin
                e.we = 1;
            end else begin
                e.err = 1;
            end
        end
        return e;
    endfunction

    task automatic run_frame(input int pre, input logic [1:0] op,
                             input logic [4:0] pa, input logic [4:0] ra,
                             input logic [1:0] ta, input logic [15:0] d,
                             input int abort);
        int b_we, b_re, b_err, b_tl;
        logic [1:32] v;
        b_we = n_we; b_re = n_re; b_err = n_err; b_tl = n_tlow;
        v = {2'b01, op, pa, ra, ta, d};
        for (int i = 0; i < pre; i++) begin
            m_en = 1'b1; m_val = 1'b1;
            repeat (HALF) @(negedge clk);
            mdc = 1'b1;
            repeat (HALF) @(negedge clk);
            mdc = 1'b0;
        end
        for (int b = 1; b <= 32; b++) begin
            m_en  = !(op == 2'b10 && b >= 15);
            m_val = v[b];
            repeat (HALF) @(negedge clk);
            rx[b] = line;
            mdc = 1'b1;
            if (b == abort) return;
            repeat (HALF) @(negedge clk);
            mdc = 1'b0;
        end
        m_en = 1'b0;
        for (int i = 0; i < TRAIL; i++) begin
            repeat (HALF) @(negedge clk);
            mdc = 1'b1;
            repeat (HALF) @(negedge clk);
            mdc = 1'b0;
        end
        repeat (4) @(negedge clk);
        d_we = n_we - b_we; d_re = n_re - b_re;
        d_err = n_err - b_err; d_tlow = n_tlow - b_tl;
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++;
        if ({mdio_t, mdio_o, reg_we, reg_re, frame_err, busy} !== 6'b110000) begin
            errors++;
            $display("FAIL reset_ctl got %b want 110000",
                     {mdio_t, mdio_o, reg_we, reg_re, frame_err, busy});
        end
        checks++;
        if ({reg_addr, reg_wdata} !== 21'd0) begin
            errors++;
            $display("FAIL reset_regs got %h want 0", {reg_addr, reg_wdata});
        end
        nRST = 1'b1;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_write;
        exp_t e;
        e = model(32 + TRAIL, 2'b01, PHY, 5'h04, 2'b10, 16'h01E1);
        run_frame(32, 2'b01, PHY, 5'h04, 2'b10, 16'h01E1, 0);
        checks++;
        if (d_we !== e.we) begin
            errors++; $display("FAIL wr_we got %0d want %0d", d_we, e.we);
        end
        checks++;
        if ({we_addr, we_data} !== {e.addr, e.wdata}) begin
            errors++;
            $display("FAIL wr_data got %h/%h want %h/%h", we_addr, we_data, e.addr, e.wdata);
        end
        checks++;
        if (d_tlow !== 0 || d_re !== 0) begin
            errors++; $display("FAIL wr_quiet got tlow=%0d re=%0d want 0/0", d_tlow, d_re);
        end
    endtask

    task automatic test_read;
        exp_t e;
        mem[2] = 16'h0141;
        e = model(32 + TRAIL, 2'b10, PHY, 5'h02, 2'b10, 16'h0);
        run_frame(32, 2'b10, PHY, 5'h02, 2'b10, 16'h0, 0);
        checks++;
        if (d_re !== e.re || re_addr !== e.addr) begin
            errors++; $display("FAIL rd_re got %0d@%h want %0d@%h", d_re, re_addr, e.re, e.addr);
        end
        checks++;
        if (rx[16] !== 1'b0) begin
            errors++; $display("FAIL rd_ta got %b want 0", rx[16]);
        end
        checks++;
        if (rx[17:32] !== e.rdata) begin
            errors++; $display("FAIL rd_data got %h want %h", rx[17:32], e.rdata);
        end
        checks++;
        if (mdio_t !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL rd_release got t=%b busy=%b want 1/0", mdio_t, busy);
        end
    endtask

    task automatic test_short_preamble;
        exp_t e;
        e = model(20 + TRAIL, 2'b10, PHY, 5'h05, 2'b10, 16'h0);
        run_frame(20, 2'b10, PHY, 5'h05, 2'b10, 16'h0, 0);
        checks++;
        if (d_re !== e.re || d_err !== 0) begin
            errors++; $display("FAIL short_re got %0d/%0d want %0d/0", d_re, d_err, e.re);
        end
        checks++;
        if (e.drive) begin
            if (rx[17:32] !== e.rdata) begin
                errors++; $display("FAIL short_data got %h want %h", rx[17:32], e.rdata);
            end
        end else if (d_tlow !== 0) begin
            errors++; $display("FAIL short_drive got %0d want 0", d_tlow);
        end
    endtask

    task automatic test_other_phy;
        run_frame(32, 2'b10, 5'd3, 5'h1F, 2'b10, 16'h0, 0);
        checks++;
        if (d_re !== 0 || d_tlow !== 0) begin
            errors++; $display("FAIL other_phy got re=%0d tlow=%0d want 0/0", d_re, d_tlow);
        end
        checks++;
        if (rx[15:32] !== 18'h3FFFF) begin
            errors++; $display("FAIL other_bus got %h want 3ffff", rx[15:32]);
        end
        run_frame(32, 2'b10, PHY, 5'h09, 2'b10, 16'h0, 0);
        checks++;
        if (d_re !== 1 || rx[17:32] !== mem[9]) begin
            errors++; $display("FAIL after_other got %0d/%h want 1/%h", d_re, rx[17:32], mem[9]);
        end
    endtask

    task automatic test_errors;
        exp_t e;
        e = model(32 + TRAIL, 2'b01, PHY, 5'h0A, 2'b11, 16'hFFFF);
        run_frame(32, 2'b01, PHY, 5'h0A, 2'b11, 16'hFFFF, 0);
        checks++;
        if (d_err !== e.err || d_we !== e.we) begin
            errors++; $display("FAIL err_ta got err=%0d we=%0d want %0d/%0d", d_err, d_we, e.err, e.we);
        end
        e = model(32 + TRAIL, 2'b11, 5'h1F, 5'h1F, 2'b11, 16'hFFFF);
        run_frame(32, 2'b11, 5'h1F, 5'h1F, 2'b11, 16'hFFFF, 0);
        checks++;
        if (d_err !== e.err || d_we !== e.we) begin
            errors++; $display("FAIL err_op got err=%0d we=%0d want %0d/%0d", d_err, d_we, e.err, e.we);
        end
        checks++;
        if (reg_addr !== 5'h0A) begin
            errors++; $display("FAIL addr_hold got %h want 0a", reg_addr);
        end
    endtask

    task automatic test_reset_midframe;
        mem[7] = 16'($urandom);
        run_frame(32, 2'b10, PHY, 5'h07, 2'b10, 16'h0, 24);
        checks++;
        if (mdio_t !== 1'b0) begin
            errors++; $display("FAIL mid_drive got %b want 0", mdio_t);
        end
        nRST = 1'b0;
        #1;
        checks++;
        if (mdio_t !== 1'b1 || busy !== 1'b0) begin
            errors++; $display("FAIL mid_reset got t=%b busy=%b want 1/0", mdio_t, busy);
        end
        repeat (3) @(negedge clk);
        mdc = 1'b0;
        repeat (3) @(negedge clk);
        nRST = 1'b1;
        repeat (3) @(negedge clk);
        run_frame(32, 2'b10, PHY, 5'h07, 2'b10, 16'h0, 0);
        checks++;
        if (d_re !== 1 || rx[17:32] !== mem[7]) begin
            errors++; $display("FAIL post_reset got %0d/%h want 1/%h", d_re, rx[17:32], mem[7]);
        end
    endtask

    task automatic test_random;
        exp_t e;
        logic [4:0] pa, ra;
        logic [1:0] op;
        logic [15:0] d;
        for (int i = 0; i < 16; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                pa = 5'($urandom_range(2, 31)); op = 2'b10; ra = 5'h1F;
            end else begin
                pa = PHY; ra = 5'($urandom);
                op = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'b01;
            end
            d = 16'($urandom);
            e = model(32 + TRAIL, op, pa, ra, 2'b10, d);
            run_frame(32, op, pa, ra, 2'b10, d, 0);
            checks++;
            if (d_we !== e.we || d_re !== e.re || d_err !== e.err) begin
                errors++;
                $display("FAIL rnd%0d_strobes got %0d/%0d/%0d want %0d/%0d/%0d",
                         i, d_we, d_re, d_err, e.we, e.re, e.err);
            end
            checks++;
            if (e.we != 0) begin
                if ({we_addr, we_data} !== {e.addr, e.wdata}) begin
                    errors++;
                    $display("FAIL rnd%0d_wr got %h/%h want %h/%h", i, we_addr, we_data, e.addr, e.wdata);
                end
            end else if (e.drive) begin
                if ({rx[16], rx[17:32]} !== {1'b0, e.rdata}) begin
                    errors++;
                    $display("FAIL rnd%0d_rd got %b/%h want 0/%h", i, rx[16], rx[17:32], e.rdata);
                end
            end else if (d_tlow !== 0) begin
                errors++; $display("FAIL rnd%0d_drive got %0d want 0", i, d_tlow);
            end
        end
    endtask

    initial begin
        foreach (mem[i]) mem[i] = 16'($urandom);
        test_reset;
        test_write;
        test_read;
        test_short_preamble;
        test_other_phy;
        test_errors;
        test_reset_midframe;
        test_random;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdio_responder.md
# mdio_responder

Clause-22 MDIO management responder (PHY side) for the PL Ethernet path. It samples the MDC/MDIO pair driven by the PS GEM MDIO master and decodes read and write frames addressed to its PHY address. Decoded frames become register-port strobes toward a PL register bank, and the block drives read data back onto MDIO. It sits in front of the tri-state pad buffer, so management software sees an emulated or augmented PHY without external silicon.

## Interface
Parameters:
- `PHY_ADDR`, default 5'd1: PHY address this responder answers to.
- `SYNC_STAGES`, default 2: flip-flop depth of the MDC/MDIO input synchronisers (minimum 2).

Ports:
- `clk`  in  1  system clock. One clock domain; reset is asynchronous and active-low.
- `nRST`  in  1  asynchronous active-low reset.
- `mdc`  in  1  management clock from the master; asynchronous to `clk`.
- `mdio_i`  in  1  MDIO pad input.
- `mdio_o`  out  1  MDIO pad output value.
- `mdio_t`  out  1  pad tristate: 1 = released, 0 = driving `mdio_o`.
- `reg_addr`  out  5  register address of the current frame.
- `reg_wdata`  out  16  write data.
- `reg_we`  out  1  one-`clk` write strobe.
- `reg_re`  out  1  one-`clk` read strobe.
- `reg_rdata`  in  16  read data, valid the `clk` cycle after `reg_re`.
- `frame_err`  out  1  one-`clk` pulse on a malformed frame.
- `busy`  out  1  high from the ST bit through to the end of the frame.

## Operation
- `mdc` and `mdio_i` pass through `SYNC_STAGES` flops. MDC rise and fall are edge-detected on the synchronised signal.
- MDIO is sampled on detected MDC rise. MDIO is driven on detected MDC fall.
- Frame bit index, counted in MDC rises after the preamble:
  - ST: bits 1–2
  - OP: bits 3–4
  - PHYAD: bits 5–9
  - REGAD: bits 10–14
  - TA: bits 15–16
  - DATA: bits 17–32, MSB first
- States: IDLE, ST, OP, PHYAD, REGAD, TA, DATA.
- IDLE: a 6-bit preamble counter increments on each sampled 1 and saturates at 32. A sampled 0 with count = 32 enters ST with ST bit 1 = 0. A sampled 0 with count < 32 clears the count.
- ST: bit 2 must be 1; otherwise pulse `frame_err` and go to IDLE.
- OP: 10 = read, 01 = write. 00 or 11 → `frame_err`, IDLE.
- PHYAD: shifted in. Mismatch with `PHY_ADDR` → silently return to IDLE with the preamble count cleared. Never drive the bus for another PHY's frame.
- REGAD: after bit 14, latch `reg_addr`. For a read, pulse `reg_re` in the next `clk` and capture `reg_rdata` into the 16-bit shift register one cycle later.
- TA, read: stay released through bit 15. On the fall after bit 15, drive 0 (`mdio_t`=0).
- DATA, read: on the falls after bits 16..31, drive D15..D0. On the fall after bit 32, release (`mdio_t`=1) and return to IDLE.
- TA, write: sampled TA must be 10; otherwise `frame_err`, IDLE, no `reg_we`.
- DATA, write: shift in 16 bits. On the sample of bit 32, present `reg_wdata` and pulse `reg_we` for one `clk`, then return to IDLE.
- After every frame the preamble count restarts from 0.

## Timing
- Reset values: `mdio_t`=1, `mdio_o`=1, `reg_we`=0, `reg_re`=0, `reg_addr`=0, `reg_wdata`=0, `frame_err`=0, `busy`=0, state IDLE, preamble count 0.
- Reset is asynchronous. Asserting it mid-frame releases the bus immediately, without waiting for `clk`.
- Required clock ratio: `clk` ≥ 8× `mdc`. MDC high and low each last at least 4 `clk`.
- MDIO drive latency: `mdio_o`/`mdio_t` change `SYNC_STAGES`+1 `clk` after the physical MDC fall.
- Register-port latency:
  - `reg_re` fires `SYNC_STAGES`+1 `clk` after the physical bit-14 rise.
  - Read data is captured 2 `clk` later, well before the bit-16 fall.
- `reg_we` and `frame_err` are single-cycle. They never coincide with each other.
- `reg_addr` holds from the REGAD latch until the next REGAD latch.

## Configuration
- `MDIO_PREAMBLE_SUPPRESS_EN` defined: IDLE accepts ST after any single sampled 1 (preamble suppression, register 1 bit 6 semantics). The counter requirement drops from 32 to 1.
- Undefined: the full 32-bit preamble is mandatory. A frame with a shorter preamble is ignored: no strobes, no drive, no `frame_err`.

## Test plan
- Write, PHYAD=1, REGAD=0x04, data 0x01E1, 32-bit preamble → one `reg_we` with `reg_addr`=0x04, `reg_wdata`=0x01E1. `mdio_t` stays 1 throughout.
- Read, PHYAD=1, REGAD=0x02, bench returns 0x0141 → one `reg_re`. The master samples 0 at TA bit 2, then 0x0141 MSB-first on bits 17–32. `mdio_t` returns to 1 after bit 32.
- Read to PHYAD=3 → no `reg_re`, `mdio_t`=1 for the whole frame. The next valid frame to PHYAD=1 still succeeds.
- Write with TA=11, then frame with OP=11 → two `frame_err` pulses, zero `reg_we`.
- 20-bit preamble, then read to PHYAD=1:
  - Macro undefined → ignored, no response.
  - Macro defined → normal response.
- `nRST` low during read DATA bit 24 → `mdio_t`=1 immediately. After release, a fresh read returns correct data.
